// File: rtl/branch_ctrl_if.sv
// Bundle between the pipeline and the branch controller: the fetch-side
// prediction lookup, the EX-stage resolution inputs and the redirect/flush
// outputs. The pipeline side uses master; the controller uses slave.
interface branch_ctrl_if #(
  parameter int WordSize = 32
);
  logic [WordSize-1:0] if_pc;
  logic                pred_taken;
  logic                ex_valid;
  logic [WordSize-1:0] ex_pc;
  logic [1:0]          ex_branch_cond;
  logic                ex_branch_taken;
  logic                ex_pred_taken;
  logic [WordSize-1:0] ex_target;
  logic [WordSize-1:0] ex_fallthrough;
  logic                redirect_valid;
  logic [WordSize-1:0] redirect_pc;
  logic                flush;
  logic [15:0]         mispredict_count;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_branch_cond, ex_branch_taken,
           ex_pred_taken, ex_target, ex_fallthrough,
    input  pred_taken, redirect_valid, redirect_pc, flush, mispredict_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_branch_cond, ex_branch_taken,
           ex_pred_taken, ex_target, ex_fallthrough,
    output pred_taken, redirect_valid, redirect_pc, flush, mispredict_count
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution and redirect controller. A tagless table of 2-bit
// saturating counters feeds fetch predictions; EX-stage resolutions train the
// table, and a mispredict launches a one-cycle redirect pulse followed by a
// flush lasting FlushCycles cycles in total.
module branch_ctrl #(
  parameter int WordSize    = 32,
  parameter int BhtEntries  = 16,
  parameter int FlushCycles = 2
) (
  input  logic           clk,
  input  logic           rstn,
  branch_ctrl_if.slave   bus
);

  localparam int IdxW = $clog2(BhtEntries);
  localparam int CntW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t          state;
  logic [CntW-1:0] flush_cnt;
  logic [1:0]      bht [BhtEntries];

  logic [IdxW-1:0] if_idx;
  logic [IdxW-1:0] ex_idx;
  logic            accept;
  logic            is_cond;
  logic            mispredict;
  logic            unused_pc;

  assign if_idx = bus.if_pc[IdxW+1:2];
  assign ex_idx = bus.ex_pc[IdxW+1:2];

  // Word-offset and upper PC bits never participate in indexing.
  assign unused_pc = ^{bus.if_pc[WordSize-1:IdxW+2], bus.if_pc[1:0],
                       bus.ex_pc[WordSize-1:IdxW+2], bus.ex_pc[1:0]};

  // The lookup reads the array before any same-cycle update lands.
  assign bus.pred_taken = bht[if_idx][1];

  // Only resolutions arriving while idle are acted on; the rest are squashed.
  assign accept = bus.ex_valid && (state == IDLE);

  // Decode the branch kind and decide whether the carried prediction was wrong.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a value unassigned and infers a latch.
    is_cond    = 1'b0;
    mispredict = 1'b0;
    case (bus.ex_branch_cond)
      2'd1, 2'd2: begin
        is_cond    = 1'b1;
        mispredict = accept && (bus.ex_pred_taken != bus.ex_branch_taken);
      end
      2'd3:    mispredict = accept && !bus.ex_pred_taken;
      default: mispredict = 1'b0;
    endcase
  end

  // Train the counter selected by the EX PC on accepted conditional branches.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the table has a defined reset value (weakly not-taken), so it is
    // built from resettable flops rather than an unreset RAM.
    if (!rstn) begin
      for (int i = 0; i < BhtEntries; i++) bht[i] <= 2'b01;
    end else if (accept && is_cond) begin
      if (bus.ex_branch_taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
      end
    end
  end

  // Redirect/flush sequencer with registered outputs and mispredict counter.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, whatever the statement order.
    if (!rstn) begin
      state                <= IDLE;
      flush_cnt            <= '0;
      bus.redirect_valid   <= 1'b0;
      bus.flush            <= 1'b0;
      bus.redirect_pc      <= '0;
      bus.mispredict_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.redirect_valid <= 1'b0;
          bus.flush          <= 1'b0;
          if (mispredict) begin
            state              <= REDIRECT;
            bus.redirect_valid <= 1'b1;
            bus.flush          <= 1'b1;
            // A jump always goes to its target; a conditional follows its outcome.
            bus.redirect_pc    <= (bus.ex_branch_cond == 2'd3 || bus.ex_branch_taken)
                                  ? bus.ex_target : bus.ex_fallthrough;
            if (bus.mispredict_count != 16'hFFFF)
              bus.mispredict_count <= bus.mispredict_count + 16'd1;
          end
        end
        REDIRECT: begin
          bus.redirect_valid <= 1'b0;
          if (FlushCycles == 1) begin
            state     <= IDLE;
            bus.flush <= 1'b0;
          end else begin
            state     <= FLUSH;
            bus.flush <= 1'b1;
            flush_cnt <= CntW'(FlushCycles - 2);
          end
        end
        FLUSH: begin
          bus.redirect_valid <= 1'b0;
          if (flush_cnt == '0) begin
            state     <= IDLE;
            bus.flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: begin
          state              <= IDLE;
          bus.redirect_valid <= 1'b0;
          bus.flush          <= 1'b0;
        end
      endcase
    end
  end

endmodule
